decoder_nto2n_seq: RTL and testbench

- Parametrised, registered N-to-2^N one-hot decoder. Successor to the fixed 3-to-8 combinational decoder.
- Adds a valid/ready input handshake, an output enable, and an auto-scan mode that walks the one-hot output through every code with a programmable dwell time.
- Drives row/strobe selects in the assignment datapath and bench stimulus generators.

---
 rtl/decoder_nto2n_seq.sv | 137 +++++++++++++
 tb/tb_decoder_nto2n_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with a valid/ready input, an output
// enable that freezes the FSM, and an auto-scan mode that walks every code
// with a programmable dwell time.
module decoder_nto2n_seq #(
   parameter int unsigned N          = 3,
   parameter int unsigned DWELL      = 2,
   parameter int unsigned ACTIVE_LOW = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                mode,
   input  logic                start,
   input  logic                in_valid,
   input  logic [N-1:0]        in_data,
   output logic                in_ready,
   output logic [(2**N)-1:0]   out_code,
   output logic                out_valid,
   output logic [N-1:0]        scan_idx,
   output logic                busy,
   output logic                done
);

   localparam int unsigned W    = 2 ** N;
   localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;

   localparam logic [CntW-1:0] CntLast  = CntW'(DWELL - 1);
   localparam logic [N-1:0]    IdxLast  = {N{1'b1}};
   localparam logic [W-1:0]    IdleCode = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};

   typedef enum logic [1:0] {StIdle, StDirect, StScan, StFinish} state_e;

   state_e          state_q;
   logic [N-1:0]    data_q;
   logic [N-1:0]    scan_idx_q;
   logic [CntW-1:0] cnt_q;
   logic [W-1:0]    out_code_q;
   logic            out_valid_q;
   logic            busy_q;
   logic            done_q;
   // Set while en is low so the first enabled edge re-announces the held code.
   logic            frozen_q;

   function automatic logic [W-1:0] decode(input logic [N-1:0] sel);
      logic [W-1:0] v;
      v      = '0;
      v[sel] = 1'b1;
      return (ACTIVE_LOW != 0) ? ~v : v;
   endfunction

   // Input is accepted only in IDLE, in direct mode, with the output enabled.
   always_comb begin
      in_ready = ~rst & en & ~mode & (state_q == StIdle);
   end

   // Control FSM with registered outputs; en low holds all sequencing state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         data_q      <= '0;
         scan_idx_q  <= '0;
         cnt_q       <= '0;
         out_code_q  <= IdleCode;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         frozen_q    <= 1'b0;
      end else if (!en) begin
         out_code_q  <= IdleCode;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         frozen_q    <= 1'b1;
      end else begin
         frozen_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               out_valid_q <= 1'b0;
               done_q      <= 1'b0;
               if (!mode && in_valid) begin
                  data_q      <= in_data;
                  out_code_q  <= decode(in_data);
                  out_valid_q <= 1'b1;
                  state_q     <= StDirect;
               end else if (mode && start) begin
                  scan_idx_q  <= '0;
                  cnt_q       <= '0;
                  out_code_q  <= decode('0);
                  out_valid_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= StScan;
               end
            end
            StDirect: begin
               // After a freeze this edge re-asserts the captured code.
               out_code_q  <= decode(data_q);
               out_valid_q <= frozen_q;
               state_q     <= StIdle;
            end
            StScan: begin
               if (cnt_q == CntLast) begin
                  if (scan_idx_q == IdxLast) begin
                     out_code_q  <= IdleCode;
                     out_valid_q <= 1'b0;
                     busy_q      <= 1'b0;
                     done_q      <= 1'b1;
                     state_q     <= StFinish;
                  end else begin
                     scan_idx_q  <= scan_idx_q + 1'b1;
                     cnt_q       <= '0;
                     out_code_q  <= decode(scan_idx_q + 1'b1);
                     out_valid_q <= 1'b1;
                  end
               end else begin
                  cnt_q       <= cnt_q + 1'b1;
                  out_code_q  <= decode(scan_idx_q);
                  out_valid_q <= frozen_q;
               end
            end
            StFinish: begin
               done_q      <= 1'b0;
               out_valid_q <= 1'b0;
               scan_idx_q  <= '0;
               cnt_q       <= '0;
               state_q     <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign out_code  = out_code_q;
   assign out_valid = out_valid_q;
   assign scan_idx  = scan_idx_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Directed bench for decoder_nto2n_seq: an N=3 active-high instance and an
// N=2 active-low instance sharing clock and reset.
module tb_decoder_nto2n_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       en, mode, start, in_valid;
   logic [2:0] in_data;
   logic       in_ready, out_valid, busy, done;
   logic [7:0] out_code;
   logic [2:0] scan_idx;

   logic       a_en, a_mode, a_start, a_in_valid;
   logic [1:0] a_in_data;
   logic       a_in_ready, a_out_valid, a_busy, a_done;
   logic [3:0] a_out_code;
   logic [1:0] a_scan_idx;

   int checks   = 0;
   int failures = 0;

   logic [2:0] dv [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd3};
   logic [7:0] de [8] = '{8'h01, 8'h02, 8'h04, 8'h10, 8'h40, 8'h20, 8'h80, 8'h08};
   logic [7:0] walk [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

   decoder_nto2n_seq #(.N(3), .DWELL(2), .ACTIVE_LOW(0)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .mode     (mode),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .out_code (out_code),
      .out_valid(out_valid),
      .scan_idx (scan_idx),
      .busy     (busy),
      .done     (done)
   );

   decoder_nto2n_seq #(.N(2), .DWELL(2), .ACTIVE_LOW(1)) dut_al (
      .clk      (clk),
      .rst      (rst),
      .en       (a_en),
      .mode     (a_mode),
      .start    (a_start),
      .in_valid (a_in_valid),
      .in_data  (a_in_data),
      .in_ready (a_in_ready),
      .out_code (a_out_code),
      .out_valid(a_out_valid),
      .scan_idx (a_scan_idx),
      .busy     (a_busy),
      .done     (a_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; mode = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
      a_en = 1'b1; a_mode = 1'b0; a_start = 1'b0; a_in_valid = 1'b0; a_in_data = '0;
      tick(); tick();
      checks++; if (out_code !== 8'h00) begin failures++; $display("FAIL reset_out_code got=%h exp=00", out_code); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
      checks++; if (scan_idx !== 3'd0) begin failures++; $display("FAIL reset_scan_idx got=%0d exp=0", scan_idx); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      checks++; if (a_out_code !== 4'b1111) begin failures++; $display("FAIL reset_al_idle got=%b exp=1111", a_out_code); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_direct();
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_data = dv[i];
         #1;
         checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL direct_ready_idle[%0d] got=%b exp=1", i, in_ready); end
         tick();
         in_valid = 1'b0;
         checks++; if (out_code !== de[i] || out_valid !== 1'b1) begin
            failures++; $display("FAIL direct_code[%0d] got=%h/%b exp=%h/1", i, out_code, out_valid, de[i]); end
         checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL direct_ready_after[%0d] got=%b exp=0", i, in_ready); end
         tick();
         checks++; if (out_code !== de[i] || out_valid !== 1'b0) begin
            failures++; $display("FAIL direct_hold[%0d] got=%h/%b exp=%h/0", i, out_code, out_valid, de[i]); end
      end
   endtask

   task automatic test_scan();
      mode = 1'b1; start = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL scan_ready_mode got=%b exp=0", in_ready); end
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || out_code !== walk[i] || scan_idx !== 3'(i)
                || out_valid !== (d == 0)) begin
               failures++;
               $display("FAIL scan_step[%0d.%0d] got code=%h idx=%0d v=%b busy=%b done=%b exp code=%h idx=%0d v=%b busy=1 done=0",
                        i, d, out_code, scan_idx, out_valid, busy, done, walk[i], i, (d == 0));
            end
            tick();
         end
      end
      checks++; if (done !== 1'b1 || busy !== 1'b0 || out_code !== 8'h00) begin
         failures++; $display("FAIL scan_done got done=%b busy=%b code=%h exp 1/0/00", done, busy, out_code); end
      tick();
      checks++; if (done !== 1'b0 || scan_idx !== 3'd0) begin
         failures++; $display("FAIL scan_after got done=%b idx=%0d exp 0/0", done, scan_idx); end
   endtask

   task automatic test_freeze();
      int busy_cycles;
      bit seen_done;
      busy_cycles = 0; seen_done = 1'b0;
      mode = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 7; k++) begin
         if (busy === 1'b1) busy_cycles++;
         if (k < 6) tick();
      end
      checks++; if (scan_idx !== 3'd3 || out_code !== 8'h08) begin
         failures++; $display("FAIL freeze_pre got idx=%0d code=%h exp 3/08", scan_idx, out_code); end
      en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (busy === 1'b1) busy_cycles++;
         checks++; if (out_code !== 8'h00 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++; $display("FAIL freeze_blank[%0d] got code=%h v=%b rdy=%b exp 00/0/0", k, out_code, out_valid, in_ready); end
      end
      en = 1'b1;
      tick();
      checks++; if (out_code !== 8'h08 || out_valid !== 1'b1 || scan_idx !== 3'd3) begin
         failures++; $display("FAIL freeze_resume got code=%h v=%b idx=%0d exp 08/1/3", out_code, out_valid, scan_idx); end
      for (int k = 0; k < 40 && !seen_done; k++) begin
         if (busy === 1'b1) busy_cycles++;
         tick();
         if (done === 1'b1) seen_done = 1'b1;
      end
      checks++; if (!seen_done) begin failures++; $display("FAIL freeze_done_timeout got=no_done exp=done"); end
      checks++; if (busy_cycles != 21) begin failures++; $display("FAIL freeze_length got=%0d exp=21", busy_cycles); end
      tick();
   endtask

   task automatic test_reset_mid_scan();
      mode = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      checks++; if (scan_idx !== 3'd5) begin failures++; $display("FAIL midrst_pre got idx=%0d exp=5", scan_idx); end
      rst = 1'b1;
      tick();
      rst = 1'b0; mode = 1'b0;
      checks++; if (out_code !== 8'h00 || busy !== 1'b0 || scan_idx !== 3'd0 || done !== 1'b0) begin
         failures++; $display("FAIL midrst_state got code=%h busy=%b idx=%0d done=%b exp 00/0/0/0", out_code, busy, scan_idx, done); end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_no_done[%0d] got=%b exp=0", k, done); end
      end
      in_valid = 1'b1; in_data = 3'b010;
      tick();
      in_valid = 1'b0;
      checks++; if (out_code !== 8'h04 || out_valid !== 1'b1) begin
         failures++; $display("FAIL midrst_direct got=%h/%b exp=04/1", out_code, out_valid); end
      tick();
   endtask

   task automatic test_active_low();
      a_in_valid = 1'b1; a_in_data = 2'b10;
      tick();
      a_in_valid = 1'b0;
      checks++; if (a_out_code !== 4'b1011 || a_out_valid !== 1'b1) begin
         failures++; $display("FAIL al_decode got=%b/%b exp=1011/1", a_out_code, a_out_valid); end
      tick();
   endtask

   task automatic test_conflict();
      mode = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 3'b111;
      tick();
      start = 1'b0; in_valid = 1'b0;
      checks++; if (out_code !== 8'h80 || out_valid !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL conflict got code=%h v=%b busy=%b exp 80/1/0", out_code, out_valid, busy); end
      tick();
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
         failures++; $display("FAIL conflict_after got busy=%b v=%b exp 0/0", busy, out_valid); end
   endtask

   task automatic test_back_to_back();
      mode = 1'b0; in_valid = 1'b1; in_data = 3'd1;
      tick();
      in_data = 3'd6;
      checks++; if (out_code !== 8'h02 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
         failures++; $display("FAIL b2b_first got code=%h v=%b rdy=%b exp 02/1/0", out_code, out_valid, in_ready); end
      tick();
      checks++; if (out_code !== 8'h02 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++; $display("FAIL b2b_gap got code=%h v=%b rdy=%b exp 02/0/1", out_code, out_valid, in_ready); end
      tick();
      in_valid = 1'b0;
      checks++; if (out_code !== 8'h40 || out_valid !== 1'b1) begin
         failures++; $display("FAIL b2b_second got=%h/%b exp=40/1", out_code, out_valid); end
      tick();
   endtask

   initial begin
      test_reset();
      test_direct();
      test_scan();
      test_freeze();
      test_reset_mid_scan();
      test_active_low();
      test_conflict();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
